tridiag_det_sequencer: RTL and testbench
========================================

Name: tridiag_det_sequencer

Overview:
Stream-to-register-bus controller that drives one tridiag_det_core instance. It accepts matrix coefficients as a valid/ready word stream and writes them to the core's a/b/c address map. It then issues start, polls the done status, reads the determinant, acks the core, and presents the result on a valid/ready output. It sits between a host FIFO/DMA and the core, so software no longer sequences the register interface.

Parameters:
N, 16, matrix dimension; must match the core; 3 <= N <= 16
WIDTH, 16, coefficient width; must match the core; <= 16
TIMEOUT, 1024, maximum number of WAIT-state cycles before the job is aborted with an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  coefficient word valid
in_ready  out  1  sequencer accepts a word
in_data  in  WIDTH  coefficient, two's complement
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
out_det  out  32  determinant (core bits 31:0)
out_err  out  1  job aborted by timeout; qualifies out_valid
busy  out  1  a job is in progress
core_we  out  1  core write enable
core_address  out  8  core address
core_wdata  out  17  core write data
core_rdata  in  32  core read data (combinational on core_address)

Behaviour:
- Interface fixed: single clock clk; reset rst_n is asynchronous and active-low. The top level drives the core's rst from ~rst_n, so both blocks reset together.
- Reset values: in_ready=0, out_valid=0, out_det=0, out_err=0, busy=0, core_we=0, core_address=8'h00, core_wdata=0. State is LOAD, word count k=0, timeout counter 0.
- Input order, k = 0..3N-3:
  - a[0..N-2] for k < N-1, written to address 8'h10+k.
  - b[0..N-1] for N-1 <= k < 2N-1, written to 8'h20+(k-N+1).
  - c[0..N-2] for k >= 2N-1, written to 8'h30+(k-2N+1).
- core_wdata = {(17-WIDTH) zero bits, in_data}.
- FSM states: LOAD, START, WAIT, READ, ACK, OUT.
- LOAD:
  - in_ready=1.
  - On handshake: core_we=1, address and data as above in the same cycle, k increments.
  - Otherwise core_we=0, core_address=8'h00.
  - Handshake with k=3N-3: k clears, next state START.
- START (1 cycle): core_we=1, core_address=8'h00, core_wdata=1. Timeout counter clears. Next state WAIT.
- WAIT:
  - core_we=0, core_address=8'h01.
  - If core_rdata[0]=1, next state READ.
  - Else the counter increments. When it reaches TIMEOUT-1 without done, set out_err=1, out_det=0, next state OUT (no ACK: the core never completed).
- READ (1 cycle): core_address=8'h40; register out_det <= core_rdata, out_err <= 0. Next state ACK.
- ACK (1 cycle): core_we=1, core_address=8'h02, core_wdata=0. Next state OUT.
- OUT:
  - out_valid=1, held with out_det/out_err stable until out_ready.
  - On handshake: out_valid=0 next cycle, next state LOAD.
  - in_ready stays 0 until then; no job overlap.
- Latency:
  - Last input accepted at cycle T: START at T+1, first poll at T+2.
  - Done seen at cycle W: READ at W+1, ACK at W+2, out_valid at W+3.
- busy = (state != LOAD) || (k != 0).
- Timeout: after an error the core may remain in CALC and silently ignore later writes. Recovery requires rst_n; the sequencer takes no other action.
- Simultaneous events:
  - In_valid during START..OUT is ignored (ready low).
  - An out_ready asserted before out_valid has no effect.
- Reset mid-operation: any state returns to LOAD/k=0 asynchronously. A partially loaded job is discarded; no partial output.
- Only one core bus transaction per cycle; core_we is never asserted in WAIT or READ.

Decomposition:
- Package tridiag_det_pkg:
  - Address constants: CTRL=8'h00, STATUS=8'h01, ACK=8'h02, A_BASE=8'h10, B_BASE=8'h20, C_BASE=8'h30, DET=8'h40.
  - State enum.
  - Function for total word count 3N-2.
- Sub-module tridiag_addr_gen: maps word count k to the core address, purely combinational, parameterised by N. All counters and the FSM remain in the sequencer.

Test Plan:
- N=4, a=c=[1,1,1], b=[2,2,2,2] -> out_det=5, out_err=0; exactly 10 core writes to 10,11,12,20..23,30..32, then one write 00<=1, then ACK write to 02.
- N=4, a=c=[0,0,0], b=[1,1,1,1] -> out_det=1; busy falls in the cycle after the out handshake.
- N=4, a=c=[1,1,1], b=[-2,-2,-2,-2] (16'hFFFE) -> out_det=5; then b=[3,3,3,3] -> out_det=55 on the second back-to-back job.
- Random in_valid gaps and out_ready held low 20 cycles -> out_det stable and out_valid held; no input accepted meanwhile.
- Stub core never sets done, TIMEOUT=16 -> out_valid with out_err=1, out_det=0 exactly 16 WAIT cycles after START; no ACK write.
- rst_n pulsed low after 5 of 10 words -> all outputs at reset values immediately; a fresh full job then yields the correct result.

Source files
------------

// File: rtl/tridiag_det_pkg.sv
// Shared definitions for the tridiagonal determinant sequencer: core register map,
// sequencer states and job sizing.
package tridiag_det_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_ACK    = 8'h02;
  localparam logic [7:0] ADDR_A_BASE = 8'h10;
  localparam logic [7:0] ADDR_B_BASE = 8'h20;
  localparam logic [7:0] ADDR_C_BASE = 8'h30;
  localparam logic [7:0] ADDR_DET    = 8'h40;

  // Wide enough for the largest job (3*16-2 = 46 words)
  localparam int K_W = 6;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_ACK,
    S_OUT
  } state_t;

  function automatic int total_words(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/tridiag_addr_gen.sv
// Maps the running coefficient word index onto the core's a/b/c register windows.
module tridiag_addr_gen
  import tridiag_det_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [K_W-1:0] k,
  output logic [7:0]     addr
);

  localparam logic [K_W-1:0] B_START = K_W'(N - 1);
  localparam logic [K_W-1:0] C_START = K_W'(2 * N - 1);

  always_comb begin
    if (k < B_START) begin
      addr = ADDR_A_BASE + 8'(k);
    end else if (k < C_START) begin
      addr = ADDR_B_BASE + 8'(k - B_START);
    end else begin
      addr = ADDR_C_BASE + 8'(k - C_START);
    end
  end

endmodule

// File: rtl/tridiag_det_sequencer.sv
// Streams coefficients into a tridiag_det_core, runs one job, polls for completion
// and hands the determinant (or a timeout error) to a valid/ready consumer.
module tridiag_det_sequencer
  import tridiag_det_pkg::*;
#(
  parameter int N       = 16,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_det,
  output logic             out_err,
  output logic             busy,
  output logic             core_we,
  output logic [7:0]       core_address,
  output logic [16:0]      core_wdata,
  input  logic [31:0]      core_rdata
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(total_words(N) - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [K_W-1:0]  k;
  logic [TW-1:0]   tcnt;
  logic            armed;
  logic            in_hs;
  logic            out_hs;
  logic            done;
  logic            timed_out;
  logic [7:0]      load_addr;

  tridiag_addr_gen #(.N(N)) u_addr_gen (
    .k    (k),
    .addr (load_addr)
  );

  // armed keeps in_ready low while reset is asserted and for the first cycle after
  assign in_ready  = armed && (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign done      = core_rdata[0];
  assign timed_out = !done && (tcnt == T_LAST);
  assign busy      = (state != S_LOAD) || (k != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (in_hs && (k == K_LAST)) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done) begin
          state_nxt = S_READ;
        end else if (timed_out) begin
          state_nxt = S_OUT;
        end
      end
      S_READ:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_OUT;
      S_OUT:   if (out_hs) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Exactly one core bus transaction per cycle; writes only in LOAD, START and ACK
  always_comb begin
    core_we      = 1'b0;
    core_address = ADDR_CTRL;
    core_wdata   = '0;
    case (state)
      S_LOAD: begin
        if (in_hs) begin
          core_we      = 1'b1;
          core_address = load_addr;
          core_wdata   = {{(17 - WIDTH){1'b0}}, in_data};
        end
      end
      S_START: begin
        core_we      = 1'b1;
        core_address = ADDR_CTRL;
        core_wdata   = 17'd1;
      end
      S_WAIT:  core_address = ADDR_STATUS;
      S_READ:  core_address = ADDR_DET;
      S_ACK: begin
        core_we      = 1'b1;
        core_address = ADDR_ACK;
        core_wdata   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      k       <= '0;
      tcnt    <= '0;
      out_det <= '0;
      out_err <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (in_hs) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end
      if (state == S_START) begin
        tcnt <= '0;
      end else if ((state == S_WAIT) && !done && !timed_out) begin
        tcnt <= tcnt + 1'b1;
      end
      // A timed-out job never reaches READ, so the error result is latched here
      if ((state == S_WAIT) && timed_out) begin
        out_det <= '0;
        out_err <= 1'b1;
      end else if (state == S_READ) begin
        out_det <= core_rdata;
        out_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tridiag_det_sequencer.sv
// Directed bench for tridiag_det_sequencer with a small behavioural core model.
module tb_tridiag_det_sequencer;

  localparam int N       = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_det;
  logic             out_err;
  logic             busy;
  logic             core_we;
  logic [7:0]       core_address;
  logic [16:0]      core_wdata;
  logic [31:0]      core_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tridiag_det_sequencer #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_det      (out_det),
    .out_err      (out_err),
    .busy         (busy),
    .core_we      (core_we),
    .core_address (core_address),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata)
  );

  // Behavioural core: latches coefficients, raises done 5 cycles after start
  logic signed [15:0] ma [0:15];
  logic signed [15:0] mb [0:15];
  logic signed [15:0] mc [0:15];
  logic               done_r;
  int                 calc_cnt;
  logic [31:0]        det_r;
  bit                 never_done = 1'b0;
  logic [7:0]         wr_addr [$];
  logic [16:0]        wr_data [$];
  int                 poll_cnt = 0;

  function automatic logic [31:0] calc_det();
    longint fm2, fm1, f;
    fm2 = 1;
    fm1 = longint'(mb[0]);
    for (int i = 1; i < N; i++) begin
      f   = longint'(mb[i]) * fm1 - longint'(ma[i-1]) * longint'(mc[i-1]) * fm2;
      fm2 = fm1;
      fm1 = f;
    end
    return fm1[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r   <= 1'b0;
      calc_cnt <= 0;
      det_r    <= '0;
    end else begin
      if (core_we) begin
        wr_addr.push_back(core_address);
        wr_data.push_back(core_wdata);
        if (core_address[7:4] == 4'h1) ma[core_address[3:0]] <= core_wdata[15:0];
        if (core_address[7:4] == 4'h2) mb[core_address[3:0]] <= core_wdata[15:0];
        if (core_address[7:4] == 4'h3) mc[core_address[3:0]] <= core_wdata[15:0];
        if (core_address == 8'h00 && core_wdata[0]) calc_cnt <= 5;
        if (core_address == 8'h02) done_r <= 1'b0;
      end else if (core_address == 8'h01) begin
        poll_cnt <= poll_cnt + 1;
      end
      if (calc_cnt > 0) begin
        calc_cnt <= calc_cnt - 1;
        if (calc_cnt == 1 && !never_done) begin
          done_r <= 1'b1;
          det_r  <= calc_det();
        end
      end
    end
  end

  assign core_rdata = (core_address == 8'h01) ? {31'd0, done_r} :
                      (core_address == 8'h40) ? det_r : 32'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [15:0] d, input int gap);
    int g;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] cv, input bit gaps);
    for (int k = 0; k < 3 * N - 2; k++) begin
      send_word((k < N - 1) ? av : (k < 2 * N - 1) ? bv : cv,
                gaps ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b out_err=%0b required 0 0 0 0",
               in_ready, out_valid, busy, out_err);
    end
    checks++;
    if (core_we !== 1'b0 || core_address !== 8'h00 || core_wdata !== 17'd0 || out_det !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: we=%0b addr=%h wdata=%h det=%h required 0 00 0 0",
               core_we, core_address, core_wdata, out_det);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    int base;
    int pbase;
    logic [7:0]  ea [0:11];
    logic [16:0] ed [0:11];
    ea = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h00, 8'h02};
    ed = '{17'd1, 17'd1, 17'd1, 17'd2, 17'd2, 17'd2, 17'd2, 17'd1, 17'd1, 17'd1, 17'd1, 17'd0};
    base  = wr_addr.size();
    pbase = poll_cnt;
    send_job(16'd1, 16'd2, 16'd1, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d required 9", n);
    end
    checks++;
    if (out_det !== 32'd5 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: det=%0d err=%0b required 5 0", out_det, out_err);
    end
    checks++;
    if (poll_cnt - pbase !== 6) begin
      errors++;
      $display("FAIL basic_polls: polls=%0d required 6", poll_cnt - pbase);
    end
    checks++;
    if (wr_addr.size() - base !== 12) begin
      errors++;
      $display("FAIL basic_write_count: writes=%0d required 12", wr_addr.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (wr_addr[base+i] !== ea[i] || wr_data[base+i] !== ed[i]) begin
          errors++;
          $display("FAIL basic_write_%0d: addr=%h data=%h required %h %h",
                   i, wr_addr[base+i], wr_data[base+i], ea[i], ed[i]);
        end
      end
    end
    take_out();
  endtask

  task automatic test_busy_release();
    int n;
    send_job(16'd0, 16'd1, 16'd0, 1'b0);
    wait_out(n);
    checks++;
    if (out_det !== 32'd1 || out_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL identity_result: det=%0d err=%0b busy=%0b required 1 0 1", out_det, out_err, busy);
    end
    take_out();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    send_job(16'd1, 16'hFFFE, 16'd1, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 9 || out_det !== 32'd5 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d det=%0d err=%0b required 9 5 0", n, out_det, out_err);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop: out_valid=%0b required 0", out_valid);
    end
    send_job(16'd1, 16'd3, 16'd1, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 9 || out_det !== 32'd55 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d det=%0d err=%0b required 9 55 0", n, out_det, out_err);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int base;
    out_ready = 1'b0;
    send_job(16'd1, 16'd2, 16'd1, 1'b1);
    wait_out(n);
    base     = wr_addr.size();
    in_valid = 1'b1;
    in_data  = 16'h0007;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_det !== 32'd5 || out_err !== 1'b0 ||
          in_ready !== 1'b0 || core_we !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%0b det=%0d err=%0b in_ready=%0b we=%0b required 1 5 0 0 0",
                 i, out_valid, out_det, out_err, in_ready, core_we);
      end
      @(negedge clk);
    end
    checks++;
    if (wr_addr.size() !== base) begin
      errors++;
      $display("FAIL hold_writes: writes=%0d required %0d", wr_addr.size(), base);
    end
    in_valid = 1'b0;
    take_out();
  endtask

  task automatic test_timeout();
    int n;
    int base;
    int pbase;
    never_done = 1'b1;
    base  = wr_addr.size();
    pbase = poll_cnt;
    send_job(16'd1, 16'd2, 16'd1, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL timeout_latency: cycles=%0d required 17", n);
    end
    checks++;
    if (out_err !== 1'b1 || out_det !== 32'd0) begin
      errors++;
      $display("FAIL timeout_result: err=%0b det=%0d required 1 0", out_err, out_det);
    end
    checks++;
    if (poll_cnt - pbase !== 16) begin
      errors++;
      $display("FAIL timeout_polls: polls=%0d required 16", poll_cnt - pbase);
    end
    take_out();
    @(negedge clk);
    checks++;
    if (wr_addr.size() - base !== 11 || wr_addr[wr_addr.size()-1] !== 8'h00) begin
      errors++;
      $display("FAIL timeout_no_ack: writes=%0d last=%h required 11 00",
               wr_addr.size() - base, wr_addr[wr_addr.size()-1]);
    end
    never_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 0; k < 5; k++) send_word((k < N - 1) ? 16'd1 : 16'd2, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midjob_busy: busy=%0b required 1", busy);
    end
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 ||
        out_det !== 32'd0 || core_we !== 1'b0 || core_address !== 8'h00) begin
      errors++;
      $display("FAIL midjob_reset: busy=%0b ready=%0b valid=%0b err=%0b det=%0d we=%0b addr=%h required 0 0 0 0 0 0 00",
               busy, in_ready, out_valid, out_err, out_det, core_we, core_address);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    send_job(16'd1, 16'd2, 16'd1, 1'b0);
    wait_out(n);
    checks++;
    if (n !== 9 || out_det !== 32'd5 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_job: cycles=%0d det=%0d err=%0b required 9 5 0", n, out_det, out_err);
    end
    take_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_release();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
